// File: rtl/switch_bounce_pkg.sv
// Shared types and constants for the synthetic switch-bounce generator.
// Also carries the Galois LFSR step so other pattern blocks can reuse it.
package switch_bounce_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BOUNCE,
      SETTLE
   } state_e;

   localparam logic [15:0] LFSR_TAPS    = 16'hB400;
   localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
   endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR, free-running, synchronous active-low reset to seed.
// A zero seed would lock up, so it is replaced by 1.
module lfsr16
   import switch_bounce_pkg::*;
#(
   parameter logic [15:0] c_SEED = DEFAULT_SEED
) (
   input  logic        i_Clk,
   input  logic        i_Rst_n,
   output logic [15:0] o_State
);

   localparam logic [15:0] SEED_EFF = (c_SEED == 16'h0000) ? 16'h0001 : c_SEED;

   logic [15:0] state_q;
   logic [15:0] state_d;

   always_comb state_d = lfsr_step(state_q);

   always_ff @(posedge i_Clk) begin
      if (!i_Rst_n) state_q <= SEED_EFF;
      else          state_q <= state_d;
   end

   assign o_State = state_q;

endmodule

// File: rtl/switch_bounce_gen.sv
// Drives a new switch level with a burst of pseudo-random contact bounce,
// holds it for a settle period, then pulses done.
module switch_bounce_gen
   import switch_bounce_pkg::*;
#(
   parameter int          c_BOUNCES  = 3,
   parameter int          c_GAP_BITS = 12,
   parameter int          c_SETTLE   = 250000,
   parameter logic [15:0] c_SEED     = DEFAULT_SEED
) (
   input  logic i_Clk,
   input  logic i_Rst_n,
   input  logic i_Start,
   input  logic i_Level,
   output logic o_Switch,
   output logic o_Busy,
   output logic o_Done
);

   localparam int GW   = c_GAP_BITS + 1;
   localparam int TW   = (c_BOUNCES > 0) ? $clog2(2 * c_BOUNCES + 1) : 1;
   localparam int SW   = $clog2(c_SETTLE + 1);
   localparam int LAST = (c_BOUNCES > 0) ? 2 * c_BOUNCES - 1 : 0;
   localparam logic [16:0] GMASK = (17'd1 << c_GAP_BITS) - 17'd1;

   logic [15:0]   lfsr;
   logic [GW-1:0] gap_d;

   state_e        state_q;
   logic [GW-1:0] gap_q;
   logic [TW-1:0] tog_q;
   logic [SW-1:0] set_q;
   logic          sw_q;
   logic          tgt_q;
   logic          busy_q;
   logic          done_q;

   lfsr16 #(
      .c_SEED (c_SEED)
   ) u_lfsr (
      .i_Clk   (i_Clk),
      .i_Rst_n (i_Rst_n),
      .o_State (lfsr)
   );

   // 17-bit add so a full 16-bit gap field cannot wrap to zero
   assign gap_d = GW'(({1'b0, lfsr} & GMASK) + 17'd1);

   always_ff @(posedge i_Clk) begin
      if (!i_Rst_n) begin
         state_q <= IDLE;
         gap_q   <= '0;
         tog_q   <= '0;
         set_q   <= '0;
         sw_q    <= 1'b0;
         tgt_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (i_Start) begin
                  if (i_Level != sw_q) begin
                     tgt_q  <= i_Level;
                     sw_q   <= i_Level;
                     tog_q  <= '0;
                     gap_q  <= gap_d;
                     busy_q <= 1'b1;
                     if (c_BOUNCES == 0) begin
                        state_q <= SETTLE;
                        set_q   <= SW'(c_SETTLE);
                     end else begin
                        state_q <= BOUNCE;
                     end
                  end else begin
                     done_q <= 1'b1;
                  end
               end
            end
            BOUNCE: begin
               if (gap_q == GW'(1)) begin
                  sw_q  <= ~sw_q;
                  tog_q <= tog_q + 1'b1;
                  gap_q <= gap_d;
                  if (tog_q == TW'(LAST)) begin
                     state_q <= SETTLE;
                     set_q   <= SW'(c_SETTLE);
                  end
               end else begin
                  gap_q <= gap_q - 1'b1;
               end
            end
            SETTLE: begin
               sw_q <= tgt_q;
               if (set_q == SW'(1)) begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  set_q <= set_q - 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign o_Switch = sw_q;
   assign o_Busy   = busy_q;
   assign o_Done   = done_q;

endmodule

// File: tb/tb_switch_bounce_gen.sv
// Bench for switch_bounce_gen: schedule-based reference model checked every
// cycle, hand-computed gap sequences after reseed, and a debounce loopback.
module tb_switch_bounce_gen;

   localparam int          NB     = 3;
   localparam int          GB     = 3;
   localparam int          ST     = 20;
   localparam logic [15:0] SEED   = 16'hACE1;
   localparam int          DB_LIM = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic level = 1'b0;
   logic sw;
   logic busy;
   logic done;

   always #5 clk = ~clk;

   switch_bounce_gen #(
      .c_BOUNCES  (NB),
      .c_GAP_BITS (GB),
      .c_SETTLE   (ST),
      .c_SEED     (SEED)
   ) dut (
      .i_Clk    (clk),
      .i_Rst_n  (rst_n),
      .i_Start  (start),
      .i_Level  (level),
      .o_Switch (sw),
      .o_Busy   (busy),
      .o_Done   (done)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic        m_sw   = 1'b0;
   logic        m_busy = 1'b0;
   logic        m_done = 1'b0;
   logic [15:0] ref_l  = SEED;
   int          ev[$];
   int          done_at = -1;
   bit          chk_en  = 1'b0;
   int          edges[$];

   logic db_state   = 1'b0;
   int   db_cnt     = 0;
   int   db_changes = 0;

   int G[6] = '{2, 1, 5, 5, 7, 7};

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic logic [15:0] step(input logic [15:0] s);
      return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
   endfunction

   // Absolute edge times of one transition, from the reference sequence
   task automatic plan(input int c, input logic [15:0] l0);
      logic [15:0] l;
      int t;
      int g;
      l = l0;
      t = c;
      ev.delete();
      for (int k = 0; k < 2 * NB; k++) begin
         g = int'(l % (16'd1 << GB)) + 1;
         t += g;
         ev.push_back(t);
         for (int j = 0; j < g; j++) l = step(l);
      end
      done_at = t + ST;
   endtask

   initial begin : model
      forever begin
         @(posedge clk);
         cyc++;
         if (!rst_n) begin
            m_sw    = 1'b0;
            m_busy  = 1'b0;
            m_done  = 1'b0;
            ref_l   = SEED;
            ev.delete();
            done_at = -1;
            chk_en  = 1'b1;
         end else begin
            m_done = 1'b0;
            if (m_busy) begin
               if (cyc == done_at) begin
                  m_busy = 1'b0;
                  m_done = 1'b1;
               end else if (ev.size() > 0 && ev[0] == cyc) begin
                  m_sw = ~m_sw;
                  void'(ev.pop_front());
               end
            end else if (start) begin
               if (level != m_sw) begin
                  m_sw   = level;
                  m_busy = 1'b1;
                  plan(cyc, ref_l);
               end else begin
                  m_done = 1'b1;
               end
            end
            ref_l = step(ref_l);
         end
         if (sw != db_state && db_cnt < DB_LIM - 1) begin
            db_cnt++;
         end else if (db_cnt == DB_LIM - 1) begin
            db_state = sw;
            db_cnt   = 0;
            db_changes++;
         end else begin
            db_cnt = 0;
         end
      end
   end

   initial begin : cmp
      logic prev;
      prev = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (chk_en) begin
            chk("o_Switch", sw, m_sw);
            chk("o_Busy", busy, m_busy);
            chk("o_Done", done, m_done);
            if (sw !== prev) edges.push_back(cyc);
            prev = sw;
         end
      end
   end

   task automatic wait_done(output int at);
      at = -1;
      for (int i = 0; i < 300; i++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) begin
            at = cyc;
            break;
         end
      end
      chk("done_seen", at >= 0, 1);
      chk("busy_fall", busy, 0);
   endtask

   task automatic check_seq(input string nm, input int n0, input int dn);
      chk({nm, "_edges"}, edges.size(), 2 * NB + 1);
      if (edges.size() == 2 * NB + 1) begin
         chk({nm, "_first"}, edges[0], n0);
         for (int k = 0; k < 2 * NB; k++)
            chk({nm, "_gap"}, edges[k+1] - edges[k], G[k]);
         chk({nm, "_settle"}, dn - edges[2*NB], ST);
      end
      chk({nm, "_level"}, sw, 1);
   endtask

   task automatic transition(input logic lv, output int n0);
      @(negedge clk);
      edges.delete();
      start = 1'b1;
      level = lv;
      @(negedge clk);
      start = 1'b0;
      n0 = cyc;
   endtask

   initial begin : wdog
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin : main
      int n0;
      int dn;
      int ch0;
      logic tg[3];
      tg[0] = 1'b0;
      tg[1] = 1'b1;
      tg[2] = 1'b0;

      repeat (3) @(negedge clk);
      chk("rst_switch", sw, 0);
      chk("rst_busy", busy, 0);
      rst_n = 1'b1;
      edges.delete();
      repeat (100) @(negedge clk);
      chk("idle_edges", edges.size(), 0);

      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      start = 1'b1;
      level = 1'b1;
      edges.delete();
      @(negedge clk);
      start = 1'b0;
      n0 = cyc;
      chk("accept_busy", busy, 1);
      chk("accept_sw", sw, 1);
      repeat (3) @(negedge clk);
      start = 1'b1;
      level = 1'b0;
      @(negedge clk);
      start = 1'b0;
      wait_done(dn);
      check_seq("clean", n0, dn);

      transition(1'b1, n0);
      chk("same_done", done, 1);
      chk("same_busy", busy, 0);
      @(negedge clk);
      chk("same_done_w", done, 0);
      repeat (5) @(negedge clk);
      chk("same_edges", edges.size(), 0);

      transition(1'b0, n0);
      for (int i = 0; i < 100 && edges.size() < 3; i++) @(negedge clk);
      chk("mid_edges", edges.size(), 3);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("mid_rst_sw", sw, 0);
      chk("mid_rst_busy", busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      start = 1'b1;
      level = 1'b1;
      edges.delete();
      @(negedge clk);
      start = 1'b0;
      n0 = cyc;
      wait_done(dn);
      check_seq("reseed", n0, dn);

      for (int t = 0; t < 3; t++) begin
         ch0 = db_changes;
         transition(tg[t], n0);
         wait_done(dn);
         repeat (2) @(negedge clk);
         chk("loop_changes", db_changes - ch0, 1);
         chk("loop_level", db_state, tg[t]);
         chk("loop_edges", edges.size(), 2 * NB + 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
